// File: rtl/mmio_responder_pkg.sv
// Shared MMIO map for the responder: window base, register offsets and status bit positions.
// Software headers and the PDU derive their register layout from these constants.
package mmio_responder_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h0000_7F00;

  localparam logic [7:0] OFF_LED       = 8'h00;
  localparam logic [7:0] OFF_SW        = 8'h04;
  localparam logic [7:0] OFF_TX_DATA   = 8'h08;
  localparam logic [7:0] OFF_TX_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RX_STATUS = 8'h10;
  localparam logic [7:0] OFF_RX_DATA   = 8'h14;
  localparam logic [7:0] OFF_CYCLE     = 8'h18;

  localparam int TX_FULL_BIT  = 0;
  localparam int TX_EMPTY_BIT = 1;
  localparam int TX_COUNT_LSB = 8;
  localparam int TX_COUNT_MSB = 15;
  localparam int TX_OVF_BIT   = 16;
  localparam int RX_FULL_BIT  = 0;

endpackage

// File: rtl/mmio_responder_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; the count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: decodes a 256-byte window out of the CPU data bus and forwards everything
// else to data memory. Provides LEDs, synchronised switches, TX FIFO, RX holding register, cycle counter.
module mmio_responder #(
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE = mmio_responder_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic [31:0] dm_addr,
  output logic        dm_we,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  import mmio_responder_pkg::*;

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic          is_mmio;
  logic [7:0]    offset;
  logic          mmio_we;
  logic [31:0]   mmio_rdata;
  logic [31:0]   tx_status;

  logic [15:0]   sw_meta;
  logic [15:0]   sw_sync;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  logic          tx_ovf;
  logic          rx_full;
  logic [31:0]   rx_hold;
  logic [31:0]   cycle;

  assign is_mmio  = (mem_addr[31:8] == MMIO_BASE[31:8]);
  assign offset   = mem_addr[7:0];
  assign mmio_we  = mem_we & is_mmio;

  assign dm_addr  = mem_addr;
  assign dm_din   = mem_din;
  assign dm_we    = mem_we & ~is_mmio;
  assign mem_dout = is_mmio ? mmio_rdata : dm_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= '0;
    end else if (mmio_we && offset == OFF_LED) begin
      led <= mem_din[15:0];
    end
  end

  // Switches are asynchronous to clk; two flops before anything reads them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  assign tx_push  = mmio_we && offset == OFF_TX_DATA;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_valid = ~tx_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (mem_din),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  // A status write clears the sticky overflow even if a drop happens in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ovf <= 1'b0;
    end else if (mmio_we && offset == OFF_TX_STATUS) begin
      tx_ovf <= 1'b0;
    end else if (tx_push && tx_full && !tx_pop) begin
      tx_ovf <= 1'b1;
    end
  end

  assign rx_ready = ~rx_full;

  // Capture and clear are exclusive: capture needs rx_full low, clearing only matters when it is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else if (rx_valid && !rx_full) begin
      rx_full <= 1'b1;
      rx_hold <= rx_data;
    end else if (mmio_we && offset == OFF_RX_STATUS) begin
      rx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle <= '0;
    else      cycle <= cycle + 32'd1;
  end

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    tx_status                            = '0;
    tx_status[TX_FULL_BIT]               = tx_full;
    tx_status[TX_EMPTY_BIT]              = tx_empty;
    tx_status[TX_COUNT_MSB:TX_COUNT_LSB] = 8'(tx_count);
    tx_status[TX_OVF_BIT]                = tx_ovf;
  end

  always_comb begin
    mmio_rdata = '0;
    case (offset)
      OFF_LED:       mmio_rdata = {16'b0, led};
      OFF_SW:        mmio_rdata = {16'b0, sw_sync};
      OFF_TX_STATUS: mmio_rdata = tx_status;
      OFF_RX_STATUS: mmio_rdata[RX_FULL_BIT] = rx_full;
      OFF_RX_DATA:   mmio_rdata = rx_hold;
      OFF_CYCLE:     mmio_rdata = cycle;
      default:       mmio_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus randomized TX traffic
// checked against a queue-based model of the FIFO and its sticky overflow flag.
module tb_mmio_responder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_7F00;

  localparam logic [7:0] R_LED = 8'h00, R_SW = 8'h04, R_TXD = 8'h08, R_TXS = 8'h0C;
  localparam logic [7:0] R_RXS = 8'h10, R_RXD = 8'h14, R_CYC = 8'h18;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we;
  logic [31:0] dm_addr, dm_din, dm_dout;
  logic        dm_we;
  logic [15:0] sw, led;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int passed = 0;
  int total  = 0;

  logic [31:0] tx_q[$];
  logic        ovf_m;

  mmio_responder #(.TX_DEPTH(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .dm_addr(dm_addr), .dm_we(dm_we), .dm_din(dm_din), .dm_dout(dm_dout),
    .sw(sw), .led(led),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tx_status_of(input int n, input logic ovf);
    return {15'b0, ovf, 8'(n), 6'b0, 1'(n == 0), 1'(n == DEPTH)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
    mem_addr = BASE | {24'b0, off};
    mem_we   = 1'b1;
    mem_din  = d;
    tick();
    mem_we   = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
    mem_addr = BASE | {24'b0, off};
    mem_we   = 1'b0;
    #1;
    d = mem_dout;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b0; mem_addr = 32'h0; mem_we = 1'b0; mem_din = 32'h0; dm_dout = 32'h0;
    sw = 16'h0; tx_ready = 1'b0; rx_data = 32'h0; rx_valid = 1'b0;
    #2;
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else passed++;
    total++; if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready: got %b want 1", rx_ready); else passed++;
    total++; if (led !== 16'h0) $display("FAIL reset_led: got %h want 0000", led); else passed++;
    bus_read(R_TXS, r);
    total++; if (r !== tx_status_of(0, 1'b0)) $display("FAIL reset_tx_status: got %h want %h", r, tx_status_of(0, 1'b0)); else passed++;
    bus_read(R_CYC, r);
    total++; if (r !== 32'h0) $display("FAIL reset_cycle: got %h want 0", r); else passed++;
    bus_read(R_RXD, r);
    total++; if (r !== 32'h0) $display("FAIL reset_rx_data: got %h want 0", r); else passed++;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic test_led();
    logic [31:0] r, d;
    mem_addr = BASE; mem_we = 1'b1; mem_din = 32'h1234_ABCD;
    #1;
    total++; if (dm_we !== 1'b0) $display("FAIL led_dm_we: got %b want 0", dm_we); else passed++;
    tick(); mem_we = 1'b0;
    total++; if (led !== 16'hABCD) $display("FAIL led_load: got %h want abcd", led); else passed++;
    bus_read(R_LED, r);
    total++; if (r !== 32'h0000_ABCD) $display("FAIL led_read: got %h want 0000abcd", r); else passed++;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      bus_write(R_LED, d);
      bus_read(R_LED, r);
      total++; if (r !== {16'b0, d[15:0]}) $display("FAIL led_rand: got %h want %h", r, {16'b0, d[15:0]}); else passed++;
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] r, d;
    mem_addr = 32'h0000_0010; mem_we = 1'b1; mem_din = 32'd5;
    #1;
    total++; if (dm_we !== 1'b1) $display("FAIL pass_dm_we: got %b want 1", dm_we); else passed++;
    total++; if (dm_din !== 32'd5) $display("FAIL pass_dm_din: got %h want 5", dm_din); else passed++;
    total++; if (dm_addr !== 32'h10) $display("FAIL pass_dm_addr: got %h want 10", dm_addr); else passed++;
    tick();
    mem_we = 1'b0; d = $urandom; dm_dout = d;
    #1;
    total++; if (mem_dout !== d) $display("FAIL pass_read: got %h want %h", mem_dout, d); else passed++;
    mem_addr = BASE - 32'd4; mem_we = 1'b1; mem_din = 32'h77;
    #1;
    total++; if (dm_we !== 1'b1) $display("FAIL pass_below_window: got %b want 1", dm_we); else passed++;
    mem_addr = BASE + 32'h100;
    #1;
    total++; if (dm_we !== 1'b1) $display("FAIL pass_above_window: got %b want 1", dm_we); else passed++;
    mem_addr = BASE | 32'h1C;
    #1;
    total++; if (dm_we !== 1'b0) $display("FAIL unmapped_dm_we: got %b want 0", dm_we); else passed++;
    tick();
    bus_read(8'h1C, r);
    total++; if (r !== 32'h0) $display("FAIL unmapped_read: got %h want 0", r); else passed++;
    bus_read(R_TXD, r);
    total++; if (r !== 32'h0) $display("FAIL txdata_read_zero: got %h want 0", r); else passed++;
  endtask

  task automatic test_sw();
    logic [31:0] r;
    logic [15:0] old_v, new_v;
    old_v = 16'h0;
    new_v = 16'($urandom) | 16'h0001;
    sw = new_v;
    bus_read(R_SW, r);
    total++; if (r !== {16'b0, old_v}) $display("FAIL sw_lat0: got %h want %h", r, {16'b0, old_v}); else passed++;
    tick();
    bus_read(R_SW, r);
    total++; if (r !== {16'b0, old_v}) $display("FAIL sw_lat1: got %h want %h", r, {16'b0, old_v}); else passed++;
    tick();
    bus_read(R_SW, r);
    total++; if (r !== {16'b0, new_v}) $display("FAIL sw_lat2: got %h want %h", r, {16'b0, new_v}); else passed++;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus_write(R_TXD, 32'(i));
    bus_read(R_TXS, r);
    total++; if (r !== tx_status_of(4, 1'b1)) $display("FAIL ovf_status: got %h want %h", r, tx_status_of(4, 1'b1)); else passed++;
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++; if (tx_valid !== 1'b1 || tx_data !== 32'(i)) $display("FAIL ovf_drain: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, 32'(i)); else passed++;
      tick();
    end
    total++; if (tx_valid !== 1'b0) $display("FAIL ovf_drained: got %b want 0", tx_valid); else passed++;
    tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 5; i <= 8; i++) bus_write(R_TXD, 32'(i));
    tx_ready = 1'b1;
    mem_addr = BASE | 32'h08; mem_we = 1'b1; mem_din = 32'd9;
    #1;
    total++; if (tx_data !== 32'd5) $display("FAIL fpp_head: got %h want 5", tx_data); else passed++;
    tick();
    mem_we = 1'b0; tx_ready = 1'b0;
    bus_read(R_TXS, r);
    total++; if (r !== tx_status_of(4, 1'b1)) $display("FAIL fpp_status: got %h want %h", r, tx_status_of(4, 1'b1)); else passed++;
    tx_ready = 1'b1;
    for (int i = 6; i <= 9; i++) begin
      #1;
      total++; if (tx_valid !== 1'b1 || tx_data !== 32'(i)) $display("FAIL fpp_drain: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, 32'(i)); else passed++;
      tick();
    end
    tx_ready = 1'b0;
    bus_write(R_TXS, 32'h0);
    bus_read(R_TXS, r);
    total++; if (r !== tx_status_of(0, 1'b0)) $display("FAIL ovf_clear: got %h want %h", r, tx_status_of(0, 1'b0)); else passed++;
  endtask

  task automatic test_rx();
    logic [31:0] r;
    rx_valid = 1'b1; rx_data = 32'h0000_CAFE;
    #1;
    total++; if (rx_ready !== 1'b1) $display("FAIL rx_ready_idle: got %b want 1", rx_ready); else passed++;
    tick();
    rx_data = 32'h0000_BEEF;
    total++; if (rx_ready !== 1'b0) $display("FAIL rx_ready_full: got %b want 0", rx_ready); else passed++;
    bus_read(R_RXS, r);
    total++; if (r !== 32'h1) $display("FAIL rx_status_full: got %h want 1", r); else passed++;
    tick();
    bus_read(R_RXD, r);
    total++; if (r !== 32'h0000_CAFE) $display("FAIL rx_held: got %h want cafe", r); else passed++;
    bus_write(R_RXS, 32'h0);
    total++; if (rx_ready !== 1'b1) $display("FAIL rx_ready_cleared: got %b want 1", rx_ready); else passed++;
    bus_read(R_RXD, r);
    total++; if (r !== 32'h0000_CAFE) $display("FAIL rx_retained: got %h want cafe", r); else passed++;
    tick();
    rx_valid = 1'b0;
    bus_read(R_RXD, r);
    total++; if (r !== 32'h0000_BEEF) $display("FAIL rx_second: got %h want beef", r); else passed++;
    bus_write(R_RXS, 32'h0);
    bus_write(R_RXS, 32'h0);
    bus_read(R_RXS, r);
    total++; if (r !== 32'h0) $display("FAIL rx_clear_empty: got %h want 0", r); else passed++;
  endtask

  task automatic test_cycle();
    logic [31:0] c0, c1;
    int n;
    n = $urandom_range(5, 40);
    bus_read(R_CYC, c0);
    repeat (n) tick();
    bus_read(R_CYC, c1);
    total++; if (c1 - c0 !== 32'(n)) $display("FAIL cycle_delta: got %0d want %0d", c1 - c0, n); else passed++;
  endtask

  task automatic test_random_tx();
    tx_q.delete();
    ovf_m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      int          op;
      logic [31:0] d, r;
      logic        pop;
      op = $urandom_range(0, 9);
      d  = $urandom;
      tx_ready = 1'($urandom_range(0, 1));
      bus_read(R_TXS, r);
      total++; if (r !== tx_status_of(tx_q.size(), ovf_m)) $display("FAIL rand_status[%0d]: got %h want %h", i, r, tx_status_of(tx_q.size(), ovf_m)); else passed++;
      total++; if (tx_valid !== (tx_q.size() != 0)) $display("FAIL rand_valid[%0d]: got %b want %b", i, tx_valid, tx_q.size() != 0); else passed++;
      if (tx_q.size() != 0) begin
        total++; if (tx_data !== tx_q[0]) $display("FAIL rand_data[%0d]: got %h want %h", i, tx_data, tx_q[0]); else passed++;
      end
      pop = tx_ready && (tx_q.size() != 0);
      if (op < 5) begin
        mem_addr = BASE | 32'h08; mem_we = 1'b1; mem_din = d;
      end else if (op == 5) begin
        mem_addr = BASE | 32'h0C; mem_we = 1'b1; mem_din = d;
      end
      if (pop) void'(tx_q.pop_front());
      if (op < 5) begin
        if (tx_q.size() < DEPTH) tx_q.push_back(d);
        else ovf_m = 1'b1;
      end else if (op == 5) begin
        ovf_m = 1'b0;
      end
      tick();
      mem_we = 1'b0;
    end
    tx_ready = 1'b1;
    repeat (DEPTH) tick();
    tx_ready = 1'b0;
    tx_q.delete();
    bus_write(R_TXS, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(R_TXD, $urandom);
    bus_write(R_LED, 32'h5555);
    rx_valid = 1'b1; rx_data = 32'h1357_9BDF;
    tick();
    rx_valid = 1'b0;
    bus_read(R_TXS, r);
    total++; if (r !== tx_status_of(3, 1'b0)) $display("FAIL pre_reset_count: got %h want %h", r, tx_status_of(3, 1'b0)); else passed++;
    #2;
    rst = 1'b0;
    #1;
    total++; if (tx_valid !== 1'b0) $display("FAIL arst_tx_valid: got %b want 0", tx_valid); else passed++;
    total++; if (rx_ready !== 1'b1) $display("FAIL arst_rx_ready: got %b want 1", rx_ready); else passed++;
    total++; if (led !== 16'h0) $display("FAIL arst_led: got %h want 0", led); else passed++;
    bus_read(R_CYC, r);
    total++; if (r !== 32'h0) $display("FAIL arst_cycle: got %h want 0", r); else passed++;
    bus_read(R_RXD, r);
    total++; if (r !== 32'h0) $display("FAIL arst_rx_data: got %h want 0", r); else passed++;
    tick();
    rst = 1'b1;
    tick();
    bus_read(R_TXS, r);
    total++; if (r !== tx_status_of(0, 1'b0)) $display("FAIL post_reset_status: got %h want %h", r, tx_status_of(0, 1'b0)); else passed++;
  endtask

  initial begin
    test_reset();
    test_led();
    test_passthrough();
    test_sw();
    test_tx_overflow();
    test_full_push_pop();
    test_rx();
    test_cycle();
    test_random_tx();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
